bcd_serial_add_ctrl: RTL and testbench

Digit-serial controller for multi-digit BCD addition. It accepts two DIGITS-wide packed BCD operands through a valid/ready handshake and steps them, least-significant digit first, through a single one-digit BCD add cell, one digit per clock. It returns the packed BCD sum, the decimal carry-out and an invalid-digit flag through a second valid/ready handshake. It sits between operand producers (keypad/register front end) and result consumers (display driver), so wide adders share one digit cell.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_add.sv | 31 +++
 rtl/bcd_serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder.
// Contents:
//   BCD_W        width of one BCD digit
//   bcd_digit_t  one packed BCD digit
//   ctrl_state_t controller states
//   is_bcd()     true when a digit is a legal decimal digit (0..9)
package bcd_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add cell, purely combinational.
// Ports:
//   a, b   in   BCD digits (values above 9 are accepted, result not meaningful)
//   cin    in   decimal carry-in
//   digit  out  BCD result digit
//   cout   out  decimal carry-out
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Adding 6 modulo 16 skips the six unused codes A..F.
        if (raw > 5'd9) begin
            digit = raw[3:0] + 4'd6;
            cout  = 1'b1;
        end else begin
            digit = raw[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial controller for multi-digit BCD addition. Operands are taken
// through a valid/ready handshake, walked LSD first through one shared
// bcd_digit_add cell (one digit per clock), and the result is offered
// through a second valid/ready handshake.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  controller idle, operands accepted
//   a, b       in   packed BCD operands, digit 0 in bits [3:0]
//   cin        in   decimal carry-in
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   sum        out  packed BCD sum
//   cout       out  decimal carry-out of the most significant digit
//   err        out  some operand digit was greater than 9
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one digit per cycle through the add cell
// DONE  | result held, out_valid=1
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     sum_nxt;
    logic             carry;
    logic [IDX_W-1:0] idx;
    bcd_digit_t       cell_digit;
    logic             cell_cout;
    logic             accept;
    logic             last;

    bcd_digit_add u_cell (
        .a     (a_sh[BCD_W-1:0]),
        .b     (b_sh[BCD_W-1:0]),
        .cin   (carry),
        .digit (cell_digit),
        .cout  (cell_cout)
    );

    assign accept = in_valid && (state == IDLE);
    assign last   = (state == RUN) && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // New digit enters at the MSD end so digit 0 ends up in sum[3:0].
    always_comb begin
        sum_nxt                 = sum >> BCD_W;
        sum_nxt[W-1 -: BCD_W]   = cell_digit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> BCD_W;
            b_sh  <= b_sh >> BCD_W;
            carry <= cell_cout;
            idx   <= idx + IDX_W'(1);
            sum   <= sum_nxt;
            err   <= err | !is_bcd(a_sh[BCD_W-1:0]) | !is_bcd(b_sh[BCD_W-1:0]);
            if (last) begin
                cout <= cell_cout;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: a DIGITS=4 instance for the
// main directed and random sequence plus a DIGITS=1 instance for the
// single-digit corner. Expected results come from decimal arithmetic on the
// operand values (or the digit-wise rule when an operand digit is illegal).
module tb_bcd_serial_add_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    logic         in_valid1;
    logic         in_ready1;
    logic [3:0]   a1;
    logic [3:0]   b1;
    logic         cin1;
    logic         out_valid1;
    logic         out_ready1;
    logic [3:0]   sum1;
    logic         cout1;
    logic         err1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .err       (err1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_err(input logic [W-1:0] x, input logic [W-1:0] y);
        logic e = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    // Returns {cout, sum}.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W-1:0] s = '0;
        logic         co;
        longint       va = 0, vb = 0, tot, lim = 1, r;
        int           cc, raw;
        if (ref_err(x, y)) begin
            cc = int'(c);
            for (int i = 0; i < D; i++) begin
                raw = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
                if (raw > 9) begin
                    s[4*i +: 4] = 4'((raw + 6) % 16);
                    cc = 1;
                end else begin
                    s[4*i +: 4] = 4'(raw);
                    cc = 0;
                end
            end
            co = (cc != 0);
        end else begin
            for (int i = D - 1; i >= 0; i--) begin
                va = va * 10 + longint'(x[4*i +: 4]);
                vb = vb * 10 + longint'(y[4*i +: 4]);
                lim = lim * 10;
            end
            tot = va + vb + longint'(c);
            co  = (tot >= lim);
            r   = tot % lim;
            for (int i = 0; i < D; i++) begin
                s[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
        return {co, s};
    endfunction

    task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(D));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic c, input logic [W-1:0] es, input logic ec, input logic ee);
        start(x, y, c);
        check({tag, "_busy"}, 64'(in_ready), 64'd0);
        wait_done(tag);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_err"}, 64'(err), 64'(ee));
        release_result(tag);
    endtask

    initial begin
        logic [W:0]   r;
        logic [W-1:0] x, y, hs;
        logic         c, hc, he;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        a1         = '0;
        b1         = '0;
        cin1       = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();

        op("plain", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("max", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
        op("bad_digit", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        op("cin_only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Back-pressure with an ignored operand pulse in DONE.
        start(16'h4321, 16'h1111, 1'b0);
        wait_done("bp");
        hs = sum;
        hc = cout;
        he = err;
        check("bp_sum", 64'(hs), 64'h5432);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a        = 16'h9999;
                b        = 16'h9999;
                cin      = 1'b1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_sum_hold", 64'(sum), 64'(hs));
            check("bp_cout_hold", 64'(cout), 64'(hc));
            check("bp_err_hold", 64'(err), 64'(he));
        end
        in_valid = 1'b0;
        release_result("bp");
        r = ref_add(16'h2468, 16'h1357, 1'b1);
        op("after_bp", 16'h2468, 16'h1357, 1'b1, r[W-1:0], r[W], 1'b0);

        // Reset during the second RUN cycle.
        start(16'h1234, 16'h5678, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        for (int i = 0; i < D + 2; i++) begin
            tick();
            check("midrst_no_result", 64'(out_valid), 64'd0);
        end
        op("post_rst", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

        // Random operands, occasionally with illegal digits.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < D; i++) begin
                x[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
                y[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            end
            c = 1'($urandom_range(0, 1));
            r = ref_add(x, y, c);
            op("rand", x, y, c, r[W-1:0], r[W], ref_err(x, y));
        end

        // Single-digit build.
        check("d1_rst_ready", 64'(in_ready1), 64'd1);
        a1        = 4'h7;
        b1        = 4'h8;
        cin1      = 1'b1;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("d1_busy", 64'(in_ready1), 64'd0);
        tick();
        check("d1_latency", 64'(out_valid1), 64'd1);
        check("d1_sum", 64'(sum1), 64'h6);
        check("d1_cout", 64'(cout1), 64'd1);
        check("d1_err", 64'(err1), 64'd0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("d1_idle", 64'(in_ready1), 64'd1);

        a1        = 4'h3;
        b1        = 4'hC;
        cin1      = 1'b0;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        check("d1b_valid", 64'(out_valid1), 64'd1);
        check("d1b_sum", 64'(sum1), 64'h5);
        check("d1b_cout", 64'(cout1), 64'd1);
        check("d1b_err", 64'(err1), 64'd1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
